// File: rtl/serial_out_pkg.sv
// Shared definitions for the weight-vector serial transmit and receive paths.
// Word geometry, vector width and the framing state encoding live here.
package serial_out_pkg;

  localparam int LENGTH       = 16;
  localparam int MAX_FEATURES = 15;
  localparam int VEC_WIDTH    = LENGTH * (MAX_FEATURES + 1);
  localparam int FEAT_W       = 4;
  localparam int BIT_CNT_W    = $clog2(LENGTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    PARITY,
    DONE_ST
  } state_t;

  // Word 0 is the bias; word i sits at bits [i*LENGTH +: LENGTH].
  function automatic logic [LENGTH-1:0] word_sel(input logic [VEC_WIDTH-1:0] vec,
                                                 input logic [FEAT_W-1:0]    idx);
    return vec[int'(idx) * LENGTH +: LENGTH];
  endfunction

endpackage

// File: rtl/serial_out_if.sv
// Request/weight bus into the transmitter and the serial line/status back out.
interface serial_out_if;
  import serial_out_pkg::*;

  logic                 start;
  logic [FEAT_W-1:0]    feat;
  logic [VEC_WIDTH-1:0] weights;
  logic                 ser;
  logic                 busy;
  logic                 done;

  modport master (output start, feat, weights, input ser, busy, done);
  modport slave  (input start, feat, weights, output ser, busy, done);

endinterface

// File: rtl/serial_out_bit_timer.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and ticks on the terminal count.
module serial_out_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/serial_out.sv
// Framed serial transmitter for the trained weight vector: per word a start bit,
// LENGTH data bits MSB-first and an even-parity bit, words back to back.
module serial_out
  import serial_out_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic         CLK,
  input  logic         RST,
  serial_out_if.slave  bus
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(LENGTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [VEC_WIDTH-1:0] weights_q;
  logic [FEAT_W-1:0]    feat_q;
  logic [FEAT_W-1:0]    word_idx;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [LENGTH-1:0]    shreg;
  logic                 par;
  logic                 ser_q;
  logic                 busy_q;
  logic                 done_q;

  logic tick;
  logic timer_clr;
  logic accept;
  logic load_word;
  logic shift;
  logic next_word;
  logic ser_nxt;

  assign timer_clr = (state == IDLE) || (state == DONE_ST);

  serial_out_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (timer_clr),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ser_nxt is the bit belonging to the current state; it reaches the pin one edge later.
  always_comb begin
    state_nxt = state;
    ser_nxt   = 1'b0;
    accept    = 1'b0;
    load_word = 1'b0;
    shift     = 1'b0;
    next_word = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = START_BIT;
        end
      end
      START_BIT: begin
        ser_nxt = 1'b1;
        if (tick) begin
          load_word = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        ser_nxt = shreg[LENGTH-1];
        if (tick) begin
          shift = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = PARITY;
          end
        end
      end
      PARITY: begin
        ser_nxt = par;
        if (tick) begin
          if (word_idx == feat_q) begin
            state_nxt = DONE_ST;
          end else begin
            next_word = 1'b1;
            state_nxt = START_BIT;
          end
        end
      end
      DONE_ST: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      weights_q <= '0;
      feat_q    <= '0;
      word_idx  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
    end else begin
      if (accept) begin
        weights_q <= bus.weights;
        feat_q    <= bus.feat;
        word_idx  <= '0;
      end
      if (load_word) begin
        shreg   <= word_sel(weights_q, word_idx);
        bit_cnt <= '0;
        par     <= 1'b0;
      end
      if (shift) begin
        shreg   <= {shreg[LENGTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
        par     <= par ^ shreg[LENGTH-1];
      end
      if (next_word) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  // Outputs are pure registers so the line never glitches on input changes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ser_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ser_q  <= ser_nxt;
      busy_q <= (state == START_BIT) || (state == DATA) || (state == PARITY);
      done_q <= (state == DONE_ST);
    end
  end

  assign bus.ser  = ser_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_out.sv
// Directed bench for serial_out: table of frames at one clock per bit plus
// hand-written sequences for slow bit time, perturbation, reset and start/reset clash.
module tb_serial_out;
  import serial_out_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  serial_out_if bus1 ();
  serial_out_if bus4 ();

  serial_out #(.CLKS_PER_BIT(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  serial_out #(.CLKS_PER_BIT(4)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]   feat;
    logic [15:0]  w0;
    logic [15:0]  w1;
    logic [15:0]  w2;
    int           exp_busy;
    logic [127:0] exp_stream;
  } vec_t;

  vec_t vecs[4];

  logic [127:0] stream;
  int           nbusy;
  int           ndone;
  int           first_busy;
  int           done_at;
  int           idle_hi;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit slow, input logic s, input logic [3:0] f,
                        input logic [VEC_WIDTH-1:0] w);
    if (slow) begin
      bus4.start = s; bus4.feat = f; bus4.weights = w;
    end else begin
      bus1.start = s; bus1.feat = f; bus1.weights = w;
    end
  endtask

  function automatic logic [VEC_WIDTH-1:0] pack3(input logic [15:0] a, input logic [15:0] b,
                                                 input logic [15:0] c);
    logic [VEC_WIDTH-1:0] v;
    v        = '0;
    v[15:0]  = a;
    v[31:16] = b;
    v[47:32] = c;
    return v;
  endfunction

  // Pulses start, then watches win cycles; c=0 is the cycle right after the sampling edge.
  task automatic send(input bit slow, input logic [3:0] f, input logic [VEC_WIDTH-1:0] w,
                      input int win, input bit perturb);
    logic s, b, d;
    @(posedge CLK); #1;
    set_in(slow, 1'b1, f, w);
    @(posedge CLK); #1;
    set_in(slow, 1'b0, f, w);
    stream = '0; nbusy = 0; ndone = 0; first_busy = -1; done_at = -1; idle_hi = 0;
    for (int c = 0; c < win; c++) begin
      @(negedge CLK);
      s = slow ? bus4.ser  : bus1.ser;
      b = slow ? bus4.busy : bus1.busy;
      d = slow ? bus4.done : bus1.done;
      if (b) begin
        stream = {stream[126:0], s};
        nbusy++;
        if (first_busy < 0) first_busy = c;
      end else if (s) begin
        idle_hi++;
      end
      if (d) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (perturb && c == 5) set_in(slow, 1'b1, ~f, ~w);
      if (perturb && c == 6) set_in(slow, 1'b0, ~f, ~w);
    end
  endtask

  initial begin
    vecs[0] = '{4'd0, 16'hA5A5, 16'h0000, 16'h0000, 18,
                128'({1'b1, 16'hA5A5, 1'b0})};
    vecs[1] = '{4'd2, 16'h0001, 16'h8000, 16'h0003, 54,
                128'({1'b1, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 16'h0003, 1'b0})};
    vecs[2] = '{4'd1, 16'hFFFF, 16'h0000, 16'h0000, 36,
                128'({1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0})};
    vecs[3] = '{4'd0, 16'h7FFF, 16'h0000, 16'h0000, 18,
                128'({1'b1, 16'h7FFF, 1'b1})};

    RST = 1'b1;
    set_in(1'b0, 1'b0, 4'd0, '0);
    set_in(1'b1, 1'b0, 4'd0, '0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outs_cpb1", 128'({bus1.ser, bus1.busy, bus1.done}), 128'(0));
    chk("reset_outs_cpb4", 128'({bus4.ser, bus4.busy, bus4.done}), 128'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 4; i++) begin
      send(1'b0, vecs[i].feat, pack3(vecs[i].w0, vecs[i].w1, vecs[i].w2),
           vecs[i].exp_busy + 8, 1'b0);
      chk($sformatf("v%0d_stream", i), stream, vecs[i].exp_stream);
      chk($sformatf("v%0d_busy_cycles", i), 128'(nbusy), 128'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done_count", i), 128'(ndone), 128'(1));
      chk($sformatf("v%0d_done_cycle", i), 128'(done_at), 128'(vecs[i].exp_busy + 1));
      chk($sformatf("v%0d_first_busy", i), 128'(first_busy), 128'(1));
      chk($sformatf("v%0d_idle_low", i), 128'(idle_hi), 128'(0));
    end

    // Four clocks per bit, all-ones word.
    send(1'b1, 4'd0, pack3(16'hFFFF, 16'h0, 16'h0), 82, 1'b0);
    chk("cpb4_stream", stream, 128'(72'hFF_FFFF_FFFF_FFFF_FFF0));
    chk("cpb4_busy_cycles", 128'(nbusy), 128'(72));
    chk("cpb4_done_count", 128'(ndone), 128'(1));
    chk("cpb4_done_cycle", 128'(done_at), 128'(73));

    // Re-pulsed start and changed inputs mid-frame must not disturb the frame.
    send(1'b0, 4'd0, pack3(16'hA5A5, 16'h0, 16'h0), 30, 1'b1);
    chk("perturb_stream", stream, 128'({1'b1, 16'hA5A5, 1'b0}));
    chk("perturb_busy_cycles", 128'(nbusy), 128'(18));
    chk("perturb_done_count", 128'(ndone), 128'(1));

    // Reset in the middle of word 1 (all ones) of a four-word frame.
    begin
      int dn, bz;
      dn = 0; bz = 0;
      @(posedge CLK); #1;
      set_in(1'b0, 1'b1, 4'd3, {{(VEC_WIDTH-64){1'b0}}, 16'hAAAA, 16'h0F0F, 16'hFFFF, 16'h1234});
      @(posedge CLK); #1;
      bus1.start = 1'b0;
      for (int c = 0; c < 25; c++) begin
        @(negedge CLK);
        if (bus1.done) dn++;
      end
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_mid_ser", 128'(bus1.ser), 128'(0));
      chk("rst_mid_busy", 128'(bus1.busy), 128'(0));
      RST = 1'b0;
      for (int c = 0; c < 80; c++) begin
        @(negedge CLK);
        if (bus1.done) dn++;
        if (bus1.busy) bz++;
      end
      chk("rst_mid_no_done", 128'(dn), 128'(0));
      chk("rst_mid_stays_idle", 128'(bz), 128'(0));
    end
    send(1'b0, 4'd0, pack3(16'hA5A5, 16'h0, 16'h0), 26, 1'b0);
    chk("after_rst_stream", stream, 128'({1'b1, 16'hA5A5, 1'b0}));
    chk("after_rst_done_count", 128'(ndone), 128'(1));

    // start and RST on the same edge: reset wins, block stays idle.
    begin
      int act;
      act = 0;
      @(posedge CLK); #1;
      RST = 1'b1;
      set_in(1'b0, 1'b1, 4'd0, pack3(16'hA5A5, 16'h0, 16'h0));
      @(posedge CLK); #1;
      RST = 1'b0;
      bus1.start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge CLK);
        if (bus1.busy || bus1.ser || bus1.done) act++;
      end
      chk("start_rst_clash_idle", 128'(act), 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_out.md
# serial_out

Parallel-to-serial transmitter for trained regression weights: the transmit counterpart of the serial input path. When SGD completes, it latches the weight vector (bias plus one weight per feature, LENGTH bits each) and shifts it out on a single line as framed words. The frame carries a start bit and even parity. The block sits beside the SGD core in the top level and is triggered by the top-level FSM once training is done.

## Interface
- LENGTH, 16: bits per weight word.
- MAX_FEATURES, 15: maximum feature count; the vector holds MAX_FEATURES+1 words.
- VEC_WIDTH, LENGTH*(MAX_FEATURES+1): width of the weight bus.
- CLKS_PER_BIT, 1: clock cycles per serial bit; must be ≥1.
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to transmit; sampled only in IDLE.
- feat  in  4  feature count; words sent = feat+1; latched with start.
- weights  in  VEC_WIDTH  word i occupies bits [i*LENGTH +: LENGTH]; word 0 is the bias; latched with start.
- ser  out  1  serial line; idles low.
- busy  out  1  high from the cycle after start is accepted until the last bit ends.
- done  out  1  one-cycle pulse after the last bit of the last word.

## Operation
- States:
  - IDLE: start=1 latches weights and feat, clears word_idx, and moves to START_BIT.
  - START_BIT drives ser=1 for one bit time, then goes to DATA.
  - DATA shifts LENGTH bits of word word_idx out MSB-first, one per bit time, then goes to PARITY.
  - PARITY drives the XOR of the LENGTH data bits (even parity).
  - After PARITY: if word_idx == latched feat, go to DONE_ST; otherwise increment word_idx and return to START_BIT. There is no gap between words.
  - DONE_ST asserts done for one cycle, then returns to IDLE.
- Bit time: a bit counter runs 0..CLKS_PER_BIT-1 and advances to the next bit on terminal count.
- Shift register: LENGTH bits wide, loaded from the selected word when entering DATA.
- start while busy or in DONE_ST is ignored; there is no queuing.
- Changes on weights or feat after the latch do not affect the frame in progress.
- feat=0 sends the bias word only. feat=15 sends 16 words. There is no clamping.

## Timing
- Reset values: ser=0, busy=0, done=0, state=IDLE, all counters 0.
- RST asserted mid-frame aborts the frame. At the next edge ser=0 and busy=0, and done is not pulsed.
- start is sampled at edge k. The start bit appears on ser from edge k+1, and busy rises at the same edge.
- Each word takes (LENGTH+2)*CLKS_PER_BIT cycles. The whole frame takes (feat+1)*(LENGTH+2)*CLKS_PER_BIT cycles.
- busy falls and done rises at the edge ending the final parity bit. done is high for exactly one cycle.
- ser, busy and done are all registered outputs; none has a combinational path from an input.
- start and RST both high on the same edge: RST wins.

## Structure
- Shared package holds LENGTH, MAX_FEATURES, the VEC_WIDTH derivation and the state encoding (IDLE, START_BIT, DATA, PARITY, DONE_ST). The serial input side imports the same package.
- One natural sub-module, bit_timer: a CLKS_PER_BIT counter with a clear input and a one-cycle tick output.
- The top module holds the FSM, word_idx (4 bits), data bit counter (log2 LENGTH + 1 bits), shift register and parity accumulator.

## Test plan
- CLKS_PER_BIT=1, feat=0, word0=16'hA5A5, start pulse:
  - ser = 1, then 1010010110100101, then parity 0, over 18 cycles.
  - busy is high for 18 cycles and done pulses on the 19th edge.
- feat=2, words 16'h0001/16'h8000/16'h0003:
  - three back-to-back 18-bit frames with parity bits 1, 1, 0.
  - 54 busy cycles and a single done.
- CLKS_PER_BIT=4, feat=0, word0=16'hFFFF:
  - every bit is held 4 cycles, parity 0, 72 busy cycles.
- start re-pulsed at cycle 5 of a frame, and weights changed mid-frame:
  - the output stream is identical to the unperturbed run and only one done pulse occurs.
- RST asserted during word 1 of a feat=3 frame:
  - next edge ser=0 and busy=0, with no done.
  - A new start afterwards transmits a full, correct frame.
- start and RST high on the same edge:
  - the block stays in IDLE, ser=0, busy=0.
